// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: memory-stage LSU driving a req/gnt/rvalid data-memory port.
// Rev 1.0 - initial release.

package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'b000,
        MEM_HALF   = 3'b001,
        MEM_WORD   = 3'b010,
        MEM_BYTE_U = 3'b100,
        MEM_HALF_U = 3'b101
    } mem_op_e;
endpackage

module load_store_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  mem_op_e         mem_op,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            resp_valid,
    output logic            resp_is_load,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic [XLEN-1:0] resp_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]      state;
    mem_op_e         op_q;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic            mis_next;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_ext;
    logic            accept;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready && (mem_read || mem_write);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = store_data;
        mis_next   = 1'b0;
        case (mem_op)
            MEM_BYTE, MEM_BYTE_U: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            MEM_HALF, MEM_HALF_U: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{store_data[15:0]}};
                mis_next   = addr[0];
            end
            MEM_WORD: begin
                mis_next = (addr[1:0] != 2'b00);
            end
            default: begin
            end
        endcase
    end

    // Lane selection uses the captured byte offset, not the live request address.
    always_comb begin
        case (resp_addr[1:0])
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = resp_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            MEM_BYTE:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            MEM_BYTE_U: load_ext = {24'd0, byte_sel};
            MEM_HALF:   load_ext = {{16{half_sel[15]}}, half_sel};
            MEM_HALF_U: load_ext = {16'd0, half_sel};
            default:    load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= MEM_BYTE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0000;
            dmem_wdata   <= '0;
            resp_valid   <= 1'b0;
            resp_is_load <= 1'b0;
            misaligned   <= 1'b0;
            load_data    <= '0;
            resp_addr    <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q         <= mem_op;
                        resp_addr    <= addr;
                        resp_is_load <= !mem_write;
                        misaligned   <= mis_next;
                        load_data    <= '0;
                        dmem_we      <= mem_write;
                        dmem_addr    <= {addr[XLEN-1:2], 2'b00};
                        dmem_be      <= be_next;
                        dmem_wdata   <= mem_write ? wdata_next : '0;
                        if (mis_next) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            dmem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        load_data  <= load_ext;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: scoreboard bench for load_store_unit.
// Rev 1.0 - initial release.

module tb_load_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    mem_op_e     mem_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        resp_valid;
    logic        resp_is_load;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] resp_addr;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_op       (mem_op),
        .addr         (addr),
        .store_data   (store_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .resp_valid   (resp_valid),
        .resp_is_load (resp_is_load),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .resp_addr    (resp_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic        mis;
        logic [31:0] addr;
        logic [31:0] ldata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("resp_is_load", {31'd0, resp_is_load}, {31'd0, mon_e.is_load});
                check_val("resp_misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
                check_val("resp_addr", resp_addr, mon_e.addr);
                if (mon_e.is_load && !mon_e.mis)
                    check_val("load_data", load_data, mon_e.ldata);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic rd, input logic wr, input mem_op_e op,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int gdly, input int rdly, input logic [31:0] rdata,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] eld, input logic emis);
        exp_t e;
        e.is_load = rd & ~wr;
        e.mis     = emis;
        e.addr    = a;
        e.ldata   = eld;
        wait_ready();
        sb.push_back(e);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_op = op;
        addr = a; store_data = sd;
        @(negedge clk);
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        check_val("ready_c1", {31'd0, req_ready}, 32'd0);
        if (emis) begin
            check_val("mis_no_req", {31'd0, dmem_req}, 32'd0);
            check_val("mis_resp_c1", {31'd0, resp_valid}, 32'd1);
            @(negedge clk);
            check_val("mis_no_req_after", {31'd0, dmem_req}, 32'd0);
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                check_val("dmem_req", {31'd0, dmem_req}, 32'd1);
                check_val("dmem_addr", dmem_addr, {a[31:2], 2'b00});
                check_val("dmem_be", {28'd0, dmem_be}, {28'd0, ebe});
                check_val("dmem_wdata", dmem_wdata, ewd);
                check_val("dmem_we", {31'd0, dmem_we}, {31'd0, wr});
                if (i == gdly) dmem_gnt = 1'b1;
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            if (!wr) begin
                for (int i = 0; i < rdly; i++) begin
                    check_val("wait_no_req", {31'd0, dmem_req}, 32'd0);
                    check_val("wait_no_resp", {31'd0, resp_valid}, 32'd0);
                    @(negedge clk);
                end
                dmem_rvalid = 1'b1; dmem_rdata = rdata;
                @(negedge clk);
                dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_0000;
            end
            check_val("resp_pulse", {31'd0, resp_valid}, 32'd1);
            @(negedge clk);
        end
        check_val("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        check_val("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_op = MEM_WORD; addr = '0; store_data = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_req", {31'd0, dmem_req}, 32'd0);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_dmem_addr", dmem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Request with no read/write flag is dropped.
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("nop_ready", {31'd0, req_ready}, 32'd1);
        check_val("nop_req", {31'd0, dmem_req}, 32'd0);

        run_op(0, 1, MEM_BYTE,   32'h1003, 32'h0000_00AB, 0, 0, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0, 0);
        run_op(1, 0, MEM_BYTE,   32'h2001, 32'h0, 0, 0, 32'h0000_80FF, 4'b0010, 32'h0, 32'hFFFF_FF80, 0);
        run_op(1, 0, MEM_BYTE_U, 32'h2001, 32'h0, 0, 0, 32'h0000_80FF, 4'b0010, 32'h0, 32'h0000_0080, 0);
        run_op(1, 0, MEM_HALF,   32'h2002, 32'h0, 0, 0, 32'h8001_1234, 4'b1100, 32'h0, 32'hFFFF_8001, 0);
        run_op(1, 0, MEM_HALF_U, 32'h2002, 32'h0, 0, 0, 32'h8001_1234, 4'b1100, 32'h0, 32'h0000_8001, 0);
        run_op(1, 0, MEM_WORD,   32'h2000, 32'h0, 0, 0, 32'h8001_1234, 4'b1111, 32'h0, 32'h8001_1234, 0);
        run_op(1, 0, MEM_WORD,   32'h3002, 32'h0, 0, 0, 32'h0, 4'b1111, 32'h0, 32'h0, 1);
        run_op(0, 1, MEM_HALF,   32'h3001, 32'h1234, 0, 0, 32'h0, 4'b0011, 32'h0, 32'h0, 1);
        run_op(0, 1, MEM_HALF_U, 32'h5002, 32'h1234_ABCD, 1, 0, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0, 0);
        run_op(1, 0, MEM_BYTE,   32'h5000, 32'h0, 0, 2, 32'h0000_007F, 4'b0001, 32'h0, 32'h0000_007F, 0);
        run_op(1, 1, MEM_BYTE,   32'h6000, 32'h0000_0055, 0, 0, 32'h0, 4'b0001, 32'h5555_5555, 32'h0, 0);

        // Store stalled by gnt, with a load held on req_valid behind it.
        wait_ready();
        sb.push_back('{1'b0, 1'b0, 32'h4000, 32'h0});
        sb.push_back('{1'b1, 1'b0, 32'h2000, 32'h8001_1234});
        req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; mem_op = MEM_WORD;
        addr = 32'h4000; store_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; addr = 32'h2000; store_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_val("stall_req", {31'd0, dmem_req}, 32'd1);
            check_val("stall_addr", dmem_addr, 32'h4000);
            check_val("stall_wdata", dmem_wdata, 32'hDEAD_BEEF);
            check_val("stall_we", {31'd0, dmem_we}, 32'd1);
            check_val("stall_ready", {31'd0, req_ready}, 32'd0);
            if (i == 3) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        check_val("stall_resp", {31'd0, resp_valid}, 32'd1);
        check_val("stall_resp_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_val("stall_idle_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0; mem_read = 1'b0;
        check_val("second_req", {31'd0, dmem_req}, 32'd1);
        check_val("second_addr", dmem_addr, 32'h2000);
        check_val("second_we", {31'd0, dmem_we}, 32'd0);
        check_val("second_be", {28'd0, dmem_be}, 32'hF);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_1234;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check_val("second_resp", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);

        // Reset while waiting for read data; the late rvalid must be dropped.
        wait_ready();
        req_valid = 1'b1; mem_read = 1'b1; mem_op = MEM_WORD; addr = 32'h7000;
        @(negedge clk);
        req_valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val("rstw_resp", {31'd0, resp_valid}, 32'd0);
            check_val("rstw_ready", {31'd0, req_ready}, 32'd1);
            check_val("rstw_req", {31'd0, dmem_req}, 32'd0);
            check_val("rstw_load_data", load_data, 32'd0);
            check_val("rstw_resp_addr", resp_addr, 32'd0);
            check_val("rstw_dmem_addr", dmem_addr, 32'd0);
            check_val("rstw_be", {28'd0, dmem_be}, 32'd0);
            @(negedge clk);
        end
        run_op(1, 0, MEM_WORD, 32'h2000, 32'h0, 0, 1, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678, 0);

        repeat (3) @(negedge clk);
        check_val("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit. Accepts one decoded memory operation at a time from execute (read/write flags, `mem_op_e` width code, ALU-computed address, rs2 store data) and drives the data-memory request/grant/response interface. It generates word-aligned addresses, byte enables and replicated store data, extracts and sign/zero-extends load data, and flags misaligned accesses without touching memory.

## Interface
- `XLEN`, default 32, data/address width; must be 32, since byte-enable logic is 4 lanes. Taken from `riscv_pkg`.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute presents an operation.
- `req_ready` out 1: high only in IDLE while `rst` is low. Accept = `req_valid && req_ready`.
- `mem_read` in 1: load operation.
- `mem_write` in 1: store operation; wins if both flags are set.
- `mem_op` in `mem_op_e`: MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTE_U or MEM_HALF_U.
- `addr` in XLEN: byte address.
- `store_data` in XLEN: rs2 value.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out XLEN: `{addr[XLEN-1:2], 2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out XLEN: lane-replicated store data; 0 for loads.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid. Arrives at the earliest one cycle after `dmem_gnt`.
- `dmem_rdata` in XLEN: read data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_is_load` out 1: completed operation was a load.
- `load_data` out XLEN: extended load result; valid with `resp_valid` and load.
- `misaligned` out 1: completed operation was misaligned and was not performed.
- `resp_addr` out XLEN: captured byte address, for trap reporting.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - Accept with neither `mem_read` nor `mem_write` set: ignored; no response and no state change.
  - Accept with a read or write flag: capture `addr`, op, we, the be/wdata computation and `resp_addr`.
  - Misalignment rule: a HALF/HALF_U access with `addr[0]=1` is misaligned; a WORD access with `addr[1:0]≠0` is misaligned.
  - Misaligned access: go to RESP with `misaligned=1`. `dmem_req` is never raised.
  - Aligned access: go to REQ.
- **REQ**
  - `dmem_req=1`. `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are registered and held stable until the cycle `dmem_gnt=1`.
  - On gnt, a store goes to RESP and a load goes to WAIT.
  - `dmem_rvalid` is ignored in REQ.
- **WAIT**
  - `dmem_req=0`.
  - On `dmem_rvalid`, register the extracted load result into `load_data` and go to RESP.
- **RESP**
  - `resp_valid=1` for exactly one cycle, then go to IDLE.
  - `resp_is_load`, `misaligned`, `resp_addr` and `load_data` are stable in this cycle.
- Byte enables and write data, with `a=addr[1:0]`:
  - BYTE/BYTE_U: `be = 4'b0001 << a`; `wdata = {4{store_data[7:0]}}`.
  - HALF/HALF_U: `be = a[1] ? 4'b1100 : 4'b0011`; `wdata = {2{store_data[15:0]}}`.
  - WORD, and any unlisted `mem_op` encoding: `be = 4'b1111`; `wdata = store_data`.
  - Loads drive the same `be` and `wdata=0`.
  - `_U` codes on stores behave as their signed counterparts.
- Load extraction:
  - Byte = `dmem_rdata[8*a +: 8]`.
  - Half = `dmem_rdata[16*a[1] +: 16]`.
  - MEM_BYTE and MEM_HALF sign-extend. BYTE_U and HALF_U zero-extend. WORD passes through.
- Reset
  - `rst` in any state forces IDLE on the next edge.
  - All registered outputs clear to 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `resp_valid`, `resp_is_load`, `misaligned`, `load_data`, `resp_addr`.
  - `req_ready=0` while `rst` is high and 1 the cycle after it drops.
  - Reset mid-operation abandons the access. A late `dmem_rvalid` or `dmem_gnt` seen in IDLE is ignored.

## Timing
- Call the accept cycle C0.
- Store, gnt on first REQ cycle: `dmem_req` in C1, `resp_valid` in C2.
- Load, gnt in C1 and rvalid in C2: `resp_valid` with `load_data` in C3.
- Misaligned: `resp_valid` with `misaligned=1` in C1.
- Each cycle `dmem_gnt` stays low adds one cycle. Each cycle `dmem_rvalid` is delayed after gnt adds one cycle.
- `req_ready` is low from C1 until the cycle after RESP. Back-to-back accepts are spaced by at least one full operation; there is no pipelining.
- `req_ready` is the only combinational output: a function of state and `rst`. All other outputs are registered.

## Test plan
- **SB, immediate gnt:** SB, `addr=0x1003`, `store_data=0x000000AB`, gnt in C1 → C1: `dmem_addr=0x1000`, `be=4'b1000`, `wdata=0xABABABAB`, `we=1`. C2: `resp_valid=1`, `resp_is_load=0`.
- **LB/LBU:** LB `addr=0x2001` with `rdata=0x000080FF` → `load_data=0xFFFFFF80`, `resp_valid` in C3. LBU on the same access → `0x00000080`.
- **LH/LHU:** LH `addr=0x2002` with `rdata=0x80011234` → `be=4'b1100`, `load_data=0xFFFF8001`. LHU → `0x00008001`. LW `addr=0x2000` → `0x80011234`.
- **Misaligned:** LW `addr=0x3002` → C1: `resp_valid=1`, `misaligned=1`, `resp_addr=0x3002`. `dmem_req` stays 0 throughout. Repeat with SH `addr=0x3001` for the same result.
- **Gnt stall:** SW `addr=0x4000`, `store_data=0xDEADBEEF`, gnt low for 3 cycles → `dmem_req`, `addr` and `wdata` stable for 4 cycles. `resp_valid` one cycle after gnt. `req_ready=0` throughout. A second `req_valid` held during the stall is accepted only after RESP.
- **Reset in WAIT:** assert `rst` in WAIT, then `dmem_rvalid=1` after release → no `resp_valid`, all outputs 0, `req_ready=1`. A subsequent LW completes normally.
